// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the sync_fifo_fwft_level FIFO and its storage array:
//   fifo_mode_e  - read-port behaviour (standard 1-cycle latency or FWFT)
//   lvl_width()  - bit width needed to hold a fill level of 0..depth
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// Simple dual-port register array, DATA_WIDTH x DEPTH. Synchronous write and
// registered read with read enable. The array itself is not reset; only the
// read register is, so the FIFO read data comes out of reset as zero.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request; rd_data updates on the next edge
//   rd_data                 registered read data, holds when rd_en is low
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 12,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft_level.sv
// sync_fifo_fwft_level
// Synchronous FIFO of arbitrary depth with selectable read mode (standard or
// first-word-fall-through), registered fill level, hysteretic high/low
// threshold flags and sticky overflow/underflow status.
// Optional build macro SYNC_FIFO_PEAK_LEVEL_EN adds o_peak_level, a registered
// running maximum of o_level.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   i_clr                    synchronous flush (stickies untouched)
//   i_wr_en, i_wr_data       write request/data; o_full when level == DEPTH
//   i_rd_en                  STD: read request; FWFT: pop of the head word
//   o_rd_data, o_rd_valid    read data; STD valid is a pulse, FWFT valid is level
//   o_empty, o_level         level == 0, entries held
//   i_thr_high/i_thr_low     thresholds; o_high/o_low registered flags
//   i_err_clr                clears o_ovf_sticky/o_udf_sticky
//   o_peak_level             (SYNC_FIFO_PEAK_LEVEL_EN only) peak of o_level
module sync_fifo_fwft_level
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 12,
    parameter fifo_mode_e MODE       = FIFO_MODE_STD,
    parameter int         HYST       = 1,
    localparam int        LVL_W      = lvl_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic [LVL_W-1:0]      o_level,
    input  logic [LVL_W-1:0]      i_thr_high,
    input  logic [LVL_W-1:0]      i_thr_low,
    output logic                  o_high,
    output logic                  o_low,
    input  logic                  i_err_clr,
    output logic                  o_ovf_sticky,
    output logic                  o_udf_sticky
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    ,
    output logic [LVL_W-1:0]      o_peak_level
`endif
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W:0]   HYST_X   = (LVL_W + 1)'(HYST);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;
    logic             valid_q;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_rd;
    logic             ovf_evt;
    logic             udf_evt;
    logic             high_q;
    logic             low_q;
    logic             high_nxt;
    logic             low_nxt;
    logic             ovf_q;
    logic             udf_q;
    logic [LVL_W:0]   l_x;
    logic [LVL_W:0]   thh_x;
    logic [LVL_W:0]   thl_x;

    assign o_full  = (level == LVL_FULL);
    assign o_empty = (level == '0);

    assign wr_acc  = i_wr_en & ~o_full & ~i_clr;
    assign ovf_evt = i_wr_en & o_full;

    // In FWFT mode the RAM read register doubles as the output stage. A word
    // is fetched whenever the RAM holds something (level counts the staged
    // word too) and the stage is empty or being popped this cycle, which
    // keeps back-to-back pops bubble-free.
    always_comb begin
        rd_acc = 1'b0;
        ram_rd = 1'b0;
        if (MODE == FIFO_MODE_FWFT) begin
            rd_acc = i_rd_en & valid_q & ~i_clr;
            ram_rd = (level != LVL_W'(valid_q)) & (~valid_q | rd_acc) & ~i_clr;
        end else begin
            rd_acc = i_rd_en & ~o_empty & ~i_clr;
            ram_rd = rd_acc;
        end
    end

    assign udf_evt = i_rd_en & ~rd_acc & ~i_clr;

    always_comb begin
        level_nxt = level;
        if (i_clr) begin
            level_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            level_nxt = level + LVL_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Threshold compares are one bit wider than the level so that adding the
    // hysteresis can never wrap.
    always_comb begin
        l_x   = {1'b0, level_nxt};
        thh_x = {1'b0, i_thr_high};
        thl_x = {1'b0, i_thr_low};

        high_nxt = high_q;
        if (l_x >= thh_x) begin
            high_nxt = 1'b1;
        end else if ((l_x + HYST_X) < thh_x) begin
            high_nxt = 1'b0;
        end

        low_nxt = low_q;
        if (l_x <= thl_x) begin
            low_nxt = 1'b1;
        end else if (l_x > (thl_x + HYST_X)) begin
            low_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            valid_q <= 1'b0;
            high_q  <= 1'b0;
            low_q   <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level  <= level_nxt;
            high_q <= high_nxt;
            low_q  <= low_nxt;
            ovf_q  <= ovf_evt | (ovf_q & ~i_err_clr);
            udf_q  <= udf_evt | (udf_q & ~i_err_clr);

            if (i_clr) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                valid_q <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (ram_rd) begin
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
                end
                if (MODE == FIFO_MODE_FWFT) begin
                    valid_q <= ram_rd | (valid_q & ~rd_acc);
                end else begin
                    valid_q <= rd_acc;
                end
            end
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (o_rd_data)
    );

    assign o_rd_valid   = valid_q;
    assign o_level      = level;
    assign o_high       = high_q;
    assign o_low        = low_q;
    assign o_ovf_sticky = ovf_q;
    assign o_udf_sticky = udf_q;

`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    // Tracks the registered level, so it trails o_level by one cycle.
    logic [LVL_W-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (i_clr) begin
            peak_q <= '0;
        end else if (i_err_clr) begin
            peak_q <= level;
        end else if (level > peak_q) begin
            peak_q <= level;
        end
    end

    assign o_peak_level = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft_level.sv
// tb_sync_fifo_fwft_level
// Two instances (standard and FWFT read mode, DEPTH=12, HYST=2) driven with
// directed vectors. Expected read words are queued as they are written; a
// monitor per instance pops and compares whenever a word is delivered.
module tb_sync_fifo_fwft_level;
    import sync_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int LW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] s_q[$];
    logic [DW-1:0] f_q[$];
    logic [DW-1:0] s_exp;
    logic [DW-1:0] f_exp;

    logic          s_clr, s_wr, s_rd, s_ec;
    logic [DW-1:0] s_wd, s_rdata;
    logic [LW-1:0] s_thh, s_thl, s_level;
    logic          s_full, s_rvalid, s_empty, s_high, s_low, s_ovf, s_udf;

    logic          f_clr, f_wr, f_rd, f_ec;
    logic [DW-1:0] f_wd, f_rdata;
    logic [LW-1:0] f_thh, f_thl, f_level;
    logic          f_full, f_rvalid, f_empty, f_high, f_low, f_ovf, f_udf;

`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    logic [LW-1:0] s_peak, f_peak;
`endif

    sync_fifo_fwft_level #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .MODE (FIFO_MODE_STD), .HYST (2)
    ) u_std (
        .clk (clk), .rst_n (rst_n), .i_clr (s_clr),
        .i_wr_en (s_wr), .i_wr_data (s_wd), .o_full (s_full),
        .i_rd_en (s_rd), .o_rd_data (s_rdata), .o_rd_valid (s_rvalid),
        .o_empty (s_empty), .o_level (s_level),
        .i_thr_high (s_thh), .i_thr_low (s_thl), .o_high (s_high), .o_low (s_low),
        .i_err_clr (s_ec), .o_ovf_sticky (s_ovf), .o_udf_sticky (s_udf)
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
        , .o_peak_level (s_peak)
`endif
    );

    sync_fifo_fwft_level #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .MODE (FIFO_MODE_FWFT), .HYST (2)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .i_clr (f_clr),
        .i_wr_en (f_wr), .i_wr_data (f_wd), .o_full (f_full),
        .i_rd_en (f_rd), .o_rd_data (f_rdata), .o_rd_valid (f_rvalid),
        .o_empty (f_empty), .o_level (f_level),
        .i_thr_high (f_thh), .i_thr_low (f_thl), .o_high (f_high), .o_low (f_low),
        .i_err_clr (f_ec), .o_ovf_sticky (f_ovf), .o_udf_sticky (f_udf)
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
        , .o_peak_level (f_peak)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // STD: every o_rd_valid pulse delivers the next queued word.
    always @(negedge clk) begin
        if (rst_n && s_rvalid) begin
            if (s_q.size() == 0) begin
                chk("std_spurious_valid", 32'(s_rvalid), 0);
            end else begin
                s_exp = s_q.pop_front();
                chk("std_rd_data", 32'(s_rdata), 32'(s_exp));
            end
        end
    end

    // FWFT: a word is consumed when valid and pop coincide outside a flush.
    always @(negedge clk) begin
        if (rst_n && f_rvalid && f_rd && !f_clr) begin
            if (f_q.size() == 0) begin
                chk("fwft_spurious_pop", 32'(f_rvalid), 0);
            end else begin
                f_exp = f_q.pop_front();
                chk("fwft_rd_data", 32'(f_rdata), 32'(f_exp));
            end
        end
    end

    initial begin
        s_clr = 0; s_wr = 0; s_rd = 0; s_ec = 0; s_wd = '0; s_thh = 4'd8; s_thl = 4'd2;
        f_clr = 0; f_wr = 0; f_rd = 0; f_ec = 0; f_wd = '0; f_thh = 4'd8; f_thl = 4'd2;

        repeat (3) tick();
        chk("rst_level",  32'(s_level),  0);
        chk("rst_empty",  32'(s_empty),  1);
        chk("rst_full",   32'(s_full),   0);
        chk("rst_rvalid", 32'(s_rvalid), 0);
        chk("rst_rdata",  32'(s_rdata),  0);
        chk("rst_high",   32'(s_high),   0);
        chk("rst_low",    32'(s_low),    1);
        chk("rst_ovf",    32'(s_ovf),    0);
        chk("rst_udf",    32'(s_udf),    0);
        chk("rst_f_rvalid", 32'(f_rvalid), 0);
        chk("rst_f_empty",  32'(f_empty),  1);
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
        chk("rst_peak", 32'(s_peak), 0);
`endif
        rst_n = 1;
        tick();

        // ---------------- STD: fill 12, overflow, write+read at full, drain
        for (int i = 0; i < 12; i++) begin
            s_wr = 1; s_wd = 8'(i); s_q.push_back(8'(i));
            tick();
            chk("std_fill_level", 32'(s_level), i + 1);
            if (i + 1 == 2) chk("std_low_at2_up", 32'(s_low), 1);
            if (i + 1 == 4) chk("std_low_at4_up", 32'(s_low), 1);
            if (i + 1 == 5) chk("std_low_at5_up", 32'(s_low), 0);
            if (i + 1 == 7) chk("std_high_at7_up", 32'(s_high), 0);
            if (i + 1 == 8) chk("std_high_at8_up", 32'(s_high), 1);
        end
        chk("std_full", 32'(s_full), 1);
        s_wd = 8'hCC;
        tick();
        chk("std_ovf_full",  32'(s_full),  1);
        chk("std_ovf_flag",  32'(s_ovf),   1);
        chk("std_ovf_level", 32'(s_level), 12);
        s_wd = 8'hDD; s_rd = 1;
        tick();
        chk("std_wr_rd_full_level", 32'(s_level), 11);
        chk("std_wr_rd_full_ovf",   32'(s_ovf),   1);
        s_wr = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("std_drain_level", 32'(s_level), 10 - i);
            chk("std_drain_valid", 32'(s_rvalid), 1);
            if (10 - i == 6) chk("std_high_at6_dn", 32'(s_high), 1);
            if (10 - i == 5) chk("std_high_at5_dn", 32'(s_high), 0);
            if (10 - i == 2) chk("std_low_at2_dn", 32'(s_low), 1);
        end
        s_rd = 0;
        tick();
        chk("std_valid_drop", 32'(s_rvalid), 0);
        chk("std_empty", 32'(s_empty), 1);

        // ---------------- STD: underflow and sticky clear priority
        s_rd = 1;
        tick();
        chk("std_udf_set", 32'(s_udf), 1);
        s_ec = 1;
        tick();
        chk("std_udf_set_wins", 32'(s_udf), 1);
        chk("std_ovf_cleared",  32'(s_ovf), 0);
        s_rd = 0;
        tick();
        chk("std_udf_cleared", 32'(s_udf), 0);
        s_ec = 0; s_rd = 1;
        tick();
        s_rd = 0;
        chk("std_udf_reset", 32'(s_udf), 1);

        // ---------------- STD: steady write+read at level 6
        for (int i = 0; i < 6; i++) begin
            s_wr = 1; s_wd = 8'(8'h40 + i); s_q.push_back(8'(8'h40 + i));
            tick();
        end
        chk("std_level6", 32'(s_level), 6);
        s_rd = 1;
        for (int i = 0; i < 20; i++) begin
            s_wd = 8'(8'h46 + i); s_q.push_back(8'(8'h46 + i));
            tick();
            chk("std_steady_level", 32'(s_level), 6);
        end
        s_rd = 0; s_wd = 8'h60; s_q.push_back(8'h60);
        tick();
        s_wr = 0;
        chk("std_level7", 32'(s_level), 7);
        tick();
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
        chk("std_peak7", 32'(s_peak), 7);
`endif

        // ---------------- STD: flush with concurrent requests
        s_clr = 1; s_wr = 1; s_rd = 1; s_wd = 8'hEE;
        tick();
        s_q.delete();
        s_clr = 0; s_wr = 0; s_rd = 0;
        chk("std_clr_level",  32'(s_level),  0);
        chk("std_clr_empty",  32'(s_empty),  1);
        chk("std_clr_rvalid", 32'(s_rvalid), 0);
        chk("std_clr_udf",    32'(s_udf),    1);
        chk("std_clr_ovf",    32'(s_ovf),    0);
        chk("std_clr_low",    32'(s_low),    1);
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
        chk("std_clr_peak", 32'(s_peak), 0);
`endif
        tick();
        chk("std_clr_rvalid2", 32'(s_rvalid), 0);

        // ---------------- FWFT: latency of a single word into empty
        f_wr = 1; f_wd = 8'hA5; f_q.push_back(8'hA5);
        tick();
        f_wr = 0;
        chk("fwft_k_level",  32'(f_level),  1);
        chk("fwft_k_empty",  32'(f_empty),  0);
        chk("fwft_k_rvalid", 32'(f_rvalid), 0);
        tick();
        chk("fwft_k1_rvalid", 32'(f_rvalid), 1);
        chk("fwft_k1_rdata",  32'(f_rdata),  32'h A5);
        for (int i = 1; i <= 4; i++) begin
            f_wr = 1; f_wd = 8'(i); f_q.push_back(8'(i));
            tick();
            chk("fwft_head_hold", 32'(f_rdata), 32'hA5);
        end
        f_wr = 0;
        chk("fwft_level5", 32'(f_level), 5);
        f_rd = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fwft_pop_level", 32'(f_level), 4 - i);
            if (i < 4) chk("fwft_no_bubble", 32'(f_rvalid), 1);
        end
        f_rd = 0;
        chk("fwft_drained_valid", 32'(f_rvalid), 0);
        chk("fwft_drained_empty", 32'(f_empty),  1);

        // ---------------- FWFT: underflow
        f_rd = 1;
        tick();
        f_rd = 0;
        chk("fwft_udf", 32'(f_udf), 1);
        f_ec = 1;
        tick();
        f_ec = 0;
        chk("fwft_udf_clr", 32'(f_udf), 0);

        // ---------------- FWFT: full capacity, overflow, drain with wrap
        for (int i = 0; i < 12; i++) begin
            f_wr = 1; f_wd = 8'(8'h80 + i); f_q.push_back(8'(8'h80 + i));
            tick();
        end
        chk("fwft_full_level", 32'(f_level), 12);
        chk("fwft_full",       32'(f_full),  1);
        chk("fwft_high",       32'(f_high),  1);
        f_wd = 8'hFF;
        tick();
        f_wr = 0;
        chk("fwft_ovf",       32'(f_ovf),   1);
        chk("fwft_ovf_level", 32'(f_level), 12);
        f_rd = 1;
        repeat (12) tick();
        f_rd = 0;
        chk("fwft_full_drain_level", 32'(f_level), 0);
        chk("fwft_full_drain_valid", 32'(f_rvalid), 0);

        // ---------------- FWFT: flush with a word in the output stage
        for (int i = 0; i < 3; i++) begin
            f_wr = 1; f_wd = 8'(8'h11 + i); f_q.push_back(8'(8'h11 + i));
            tick();
        end
        f_wr = 0;
        tick();
        chk("fwft_pre_clr_valid", 32'(f_rvalid), 1);
        f_clr = 1; f_wr = 1; f_rd = 1; f_wd = 8'h77;
        tick();
        f_q.delete();
        f_clr = 0; f_wr = 0; f_rd = 0;
        chk("fwft_clr_rvalid", 32'(f_rvalid), 0);
        chk("fwft_clr_level",  32'(f_level),  0);
        chk("fwft_clr_ovf",    32'(f_ovf),    1);
        tick();
        chk("fwft_clr_rvalid2", 32'(f_rvalid), 0);

        tick();
        chk("std_queue_drained",  s_q.size(), 0);
        chk("fwft_queue_drained", f_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
